// File: rtl/phy_lane_scheduler.sv
// ---------------------------------------------------------------------------
// phy_lane_scheduler
//
// Shares the single clk4f serial-side word slot between the four 9-bit
// parallel lanes of the phy. Every lane feeds a small FIFO; one word per
// clk4f cycle is drained in round-robin order towards the parallel-to-serial
// converter.
//
// After reset the block emits SYNC_LEN COM characters (the sync preamble),
// then moves to ACTIVE for good. In ACTIVE it forwards buffered lane data
// and fills empty slots with IDLE characters.
//
// Ports
//   clk4f      sole clock, rising edge
//   reset      asynchronous, active-low reset
//   in0..in3   lane words: bit 8 = push request, bits 7:0 = byte
//   full       per-lane FIFO holds DEPTH entries
//   overflow   sticky per-lane flag, set when a push is dropped
//   out        scheduled word: bit 8 = 1 data, 0 = COM/IDLE filler
//   lane_sel   source lane of the last data word
//   sync_done  preamble finished
// ---------------------------------------------------------------------------
module phy_lane_scheduler #(
  parameter int         DEPTH    = 4,      // power of two, >= 2
  parameter int         SYNC_LEN = 4,      // COM words after reset release
  parameter logic [7:0] COM      = 8'hBC,
  parameter logic [7:0] IDLE     = 8'h7C
) (
  input  logic       clk4f,
  input  logic       reset,
  input  logic [8:0] in0,
  input  logic [8:0] in1,
  input  logic [8:0] in2,
  input  logic [8:0] in3,
  output logic [3:0] full,
  output logic [3:0] overflow,
  output logic [8:0] out,
  output logic [1:0] lane_sel,
  output logic       sync_done
);

  localparam int AW = $clog2(DEPTH);                      // FIFO pointer width
  localparam int CW = $clog2(DEPTH + 1);                  // FIFO count width
  localparam int SW = (SYNC_LEN > 1) ? $clog2(SYNC_LEN) : 1;

  typedef enum logic {
    ST_SYNC,
    ST_ACTIVE
  } state_t;

  state_t           state;
  logic [SW-1:0]    sync_cnt;
  logic [1:0]       rr_ptr;

  logic [8:0]       lane_in [4];
  logic [7:0]       mem     [4][DEPTH];
  logic [AW-1:0]    wr_ptr  [4];
  logic [AW-1:0]    rd_ptr  [4];
  logic [CW-1:0]    cnt     [4];

  logic [3:0]       nonempty;
  logic [3:0]       push;
  logic [3:0]       pop;
  logic [3:0]       drop;
  logic [1:0]       grant;
  logic             grant_vld;

  assign lane_in[0] = in0;
  assign lane_in[1] = in1;
  assign lane_in[2] = in2;
  assign lane_in[3] = in3;

  // -------------------------------------------------------------------------
  // Round-robin search, starting at rr_ptr, over the pre-edge FIFO counts.
  // -------------------------------------------------------------------------
  always_comb begin
    logic [1:0] cand;
    // NOTE: every variable driven here gets a default before any branch, so
    // no path leaves it unassigned and no latch is inferred.
    cand      = '0;
    grant     = rr_ptr;
    grant_vld = 1'b0;
    for (int i = 0; i < 4; i++) begin
      nonempty[i] = (cnt[i] != '0);
    end
    for (int off = 0; off < 4; off++) begin
      cand = rr_ptr + 2'(off);
      if (!grant_vld && nonempty[cand]) begin
        grant_vld = 1'b1;
        grant     = cand;
      end
    end
  end

  // -------------------------------------------------------------------------
  // Push / pop decisions. A push into a full lane still lands when that lane
  // is popped on the same edge, because the slot being written is the one
  // being read out.
  // -------------------------------------------------------------------------
  always_comb begin
    pop  = '0;
    push = '0;
    drop = '0;
    if (state == ST_ACTIVE && grant_vld) begin
      pop = 4'b0001 << grant;
    end
    for (int i = 0; i < 4; i++) begin
      push[i] = lane_in[i][8] && ((cnt[i] != CW'(DEPTH)) || pop[i]);
      drop[i] = lane_in[i][8] && !push[i];
    end
  end

  always_comb begin
    for (int i = 0; i < 4; i++) begin
      full[i] = (cnt[i] == CW'(DEPTH));
    end
  end

  // -------------------------------------------------------------------------
  // FIFO storage.
  // NOTE: the data array has no reset; emptiness is tracked by the counts
  // and pointers, so stale contents are never observed after reset.
  // -------------------------------------------------------------------------
  always_ff @(posedge clk4f) begin
    for (int i = 0; i < 4; i++) begin
      if (push[i]) begin
        mem[i][wr_ptr[i]] <= lane_in[i][7:0];
      end
    end
  end

  // FIFO pointers and counts; pointers wrap naturally since DEPTH is 2^AW.
  // NOTE: sequential state is updated only with non-blocking assignments so
  // every register samples pre-edge values, independent of block ordering.
  always_ff @(posedge clk4f or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < 4; i++) begin
        wr_ptr[i] <= '0;
        rd_ptr[i] <= '0;
        cnt[i]    <= '0;
      end
    end else begin
      for (int i = 0; i < 4; i++) begin
        if (push[i]) begin
          wr_ptr[i] <= wr_ptr[i] + AW'(1);
        end
        if (pop[i]) begin
          rd_ptr[i] <= rd_ptr[i] + AW'(1);
        end
        case ({push[i], pop[i]})
          2'b10:   cnt[i] <= cnt[i] + CW'(1);
          2'b01:   cnt[i] <= cnt[i] - CW'(1);
          default: cnt[i] <= cnt[i];
        endcase
      end
    end
  end

  // -------------------------------------------------------------------------
  // Scheduler FSM with registered outputs. SYNC emits the COM preamble and
  // never pops; ACTIVE is terminal until reset.
  // -------------------------------------------------------------------------
  always_ff @(posedge clk4f or negedge reset) begin
    if (!reset) begin
      state     <= ST_SYNC;
      sync_cnt  <= '0;
      sync_done <= 1'b0;
      out       <= 9'h000;
      lane_sel  <= 2'd0;
      rr_ptr    <= 2'd0;
      overflow  <= '0;
    end else begin
      // Dropped pushes are flagged in every state and never cleared.
      overflow <= overflow | drop;
      case (state)
        ST_SYNC: begin
          out      <= {1'b0, COM};
          sync_cnt <= sync_cnt + SW'(1);
          if (sync_cnt == SW'(SYNC_LEN - 1)) begin
            state     <= ST_ACTIVE;
            sync_done <= 1'b1;
          end
        end
        ST_ACTIVE: begin
          if (grant_vld) begin
            out      <= {1'b1, mem[grant][rd_ptr[grant]]};
            lane_sel <= grant;
            rr_ptr   <= grant + 2'd1;
          end else begin
            out <= {1'b0, IDLE};
          end
        end
        default: begin
          state <= ST_SYNC;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_phy_lane_scheduler.sv
// ---------------------------------------------------------------------------
// tb_phy_lane_scheduler
//
// Directed bench for phy_lane_scheduler with default parameters
// (DEPTH=4, SYNC_LEN=4, COM=BC, IDLE=7C). Inputs change and outputs are
// sampled 1 time unit after each rising clk4f edge.
// ---------------------------------------------------------------------------
module tb_phy_lane_scheduler;

  logic       clk4f = 1'b0;
  logic       reset = 1'b0;
  logic [8:0] in0   = '0;
  logic [8:0] in1   = '0;
  logic [8:0] in2   = '0;
  logic [8:0] in3   = '0;
  logic [3:0] full;
  logic [3:0] overflow;
  logic [8:0] out;
  logic [1:0] lane_sel;
  logic       sync_done;

  int checks = 0;
  int errors = 0;

  phy_lane_scheduler dut (
    .clk4f     (clk4f),
    .reset     (reset),
    .in0       (in0),
    .in1       (in1),
    .in2       (in2),
    .in3       (in3),
    .full      (full),
    .overflow  (overflow),
    .out       (out),
    .lane_sel  (lane_sel),
    .sync_done (sync_done)
  );

  always #5 clk4f = ~clk4f;

  // One clock: returns 1 time unit after the rising edge.
  task automatic cycle();
    @(posedge clk4f);
    #1;
  endtask

  task automatic clear_inputs();
    in0 = '0;
    in1 = '0;
    in2 = '0;
    in3 = '0;
  endtask

  // Hold reset for two edges, release it just after an edge.
  task automatic do_reset();
    reset = 1'b0;
    clear_inputs();
    cycle();
    cycle();
    reset = 1'b1;
  endtask

  // -------------------------------------------------------------------------
  task automatic test_reset();
    reset = 1'b0;
    clear_inputs();
    cycle();
    checks++;
    if (out !== 9'h000) begin
      errors++; $display("FAIL reset_out got=%h exp=%h", out, 9'h000);
    end
    checks++;
    if (lane_sel !== 2'd0) begin
      errors++; $display("FAIL reset_lane_sel got=%0d exp=0", lane_sel);
    end
    checks++;
    if (sync_done !== 1'b0) begin
      errors++; $display("FAIL reset_sync_done got=%b exp=0", sync_done);
    end
    checks++;
    if (full !== 4'b0000) begin
      errors++; $display("FAIL reset_full got=%b exp=0000", full);
    end
    checks++;
    if (overflow !== 4'b0000) begin
      errors++; $display("FAIL reset_overflow got=%b exp=0000", overflow);
    end
    reset = 1'b1;
    for (int k = 1; k <= 4; k++) begin
      cycle();
      checks++;
      if (out !== 9'h0BC) begin
        errors++; $display("FAIL preamble_out[%0d] got=%h exp=%h", k, out, 9'h0BC);
      end
      checks++;
      if (sync_done !== (k == 4)) begin
        errors++; $display("FAIL preamble_sync_done[%0d] got=%b exp=%b", k, sync_done, (k == 4));
      end
    end
    for (int k = 0; k < 3; k++) begin
      cycle();
      checks++;
      if (out !== 9'h07C || sync_done !== 1'b1) begin
        errors++; $display("FAIL idle_after_sync[%0d] got out=%h done=%b exp out=%h done=1", k, out, sync_done, 9'h07C);
      end
    end
  endtask

  // -------------------------------------------------------------------------
  task automatic test_sync_preload();
    logic [8:0] exp_out [5] = '{9'h1FF, 9'h1F5, 9'h1FA, 9'h1F4, 9'h07C};
    logic [1:0] exp_sel [5] = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd3};
    do_reset();
    in0 = 9'h1FF;
    in1 = 9'h1F5;
    in2 = 9'h1FA;
    in3 = 9'h1F4;
    cycle();
    clear_inputs();
    checks++;
    if (out !== 9'h0BC || full !== 4'b0000) begin
      errors++; $display("FAIL preload_first_edge got out=%h full=%b exp out=%h full=0000", out, full, 9'h0BC);
    end
    cycle();
    cycle();
    cycle();
    checks++;
    if (out !== 9'h0BC || sync_done !== 1'b1) begin
      errors++; $display("FAIL preload_sync_end got out=%h done=%b exp out=%h done=1", out, sync_done, 9'h0BC);
    end
    for (int k = 0; k < 5; k++) begin
      cycle();
      checks++;
      if (out !== exp_out[k] || lane_sel !== exp_sel[k]) begin
        errors++; $display("FAIL preload_drain[%0d] got out=%h sel=%0d exp out=%h sel=%0d", k, out, lane_sel, exp_out[k], exp_sel[k]);
      end
    end
  endtask

  // -------------------------------------------------------------------------
  // Continues from test_sync_preload: ACTIVE, pointer 0, all lanes empty.
  task automatic test_ptr_wrap();
    logic [8:0] exp_out [3] = '{9'h1FE, 9'h155, 9'h07C};
    logic [1:0] exp_sel [3] = '{2'd3, 2'd0, 2'd0};
    in1 = 9'h1AA;
    cycle();
    clear_inputs();
    checks++;
    if (out !== 9'h07C) begin
      errors++; $display("FAIL wrap_push_latency got=%h exp=%h", out, 9'h07C);
    end
    cycle();
    checks++;
    if (out !== 9'h1AA || lane_sel !== 2'd1) begin
      errors++; $display("FAIL wrap_lane1 got out=%h sel=%0d exp out=%h sel=1", out, lane_sel, 9'h1AA);
    end
    // Pointer is now 2.
    in0 = 9'h155;
    in3 = 9'h1FE;
    cycle();
    clear_inputs();
    checks++;
    if (out !== 9'h07C || lane_sel !== 2'd1) begin
      errors++; $display("FAIL wrap_idle_hold got out=%h sel=%0d exp out=%h sel=1", out, lane_sel, 9'h07C);
    end
    for (int k = 0; k < 3; k++) begin
      cycle();
      checks++;
      if (out !== exp_out[k] || lane_sel !== exp_sel[k]) begin
        errors++; $display("FAIL wrap_order[%0d] got out=%h sel=%0d exp out=%h sel=%0d", k, out, lane_sel, exp_out[k], exp_sel[k]);
      end
    end
  endtask

  // -------------------------------------------------------------------------
  // Lane 1 is pushed five times; the fifth push arrives on the first ACTIVE
  // edge, where lane 0 (pushed once) wins the slot, so lane 1 is not popped
  // and the fifth word must be dropped.
  task automatic test_overflow();
    logic [8:0] exp_out [5] = '{9'h1A1, 9'h1A2, 9'h1A3, 9'h1A4, 9'h07C};
    do_reset();
    for (int k = 1; k <= 5; k++) begin
      in0 = (k == 1) ? 9'h1C0 : 9'h000;
      in1 = {1'b1, 8'hA0 + 8'(k)};
      cycle();
      if (k == 3) begin
        checks++;
        if (full !== 4'b0000) begin
          errors++; $display("FAIL ovf_not_full_yet got=%b exp=0000", full);
        end
      end
      if (k == 4) begin
        checks++;
        if (full !== 4'b0010 || overflow !== 4'b0000) begin
          errors++; $display("FAIL ovf_full_after_4 got full=%b ovf=%b exp full=0010 ovf=0000", full, overflow);
        end
      end
    end
    clear_inputs();
    checks++;
    if (overflow !== 4'b0010 || full !== 4'b0010) begin
      errors++; $display("FAIL ovf_drop got ovf=%b full=%b exp ovf=0010 full=0010", overflow, full);
    end
    checks++;
    if (out !== 9'h1C0 || lane_sel !== 2'd0) begin
      errors++; $display("FAIL ovf_lane0_first got out=%h sel=%0d exp out=%h sel=0", out, lane_sel, 9'h1C0);
    end
    for (int k = 0; k < 5; k++) begin
      cycle();
      checks++;
      if (out !== exp_out[k] || lane_sel !== 2'd1 || overflow !== 4'b0010) begin
        errors++; $display("FAIL ovf_drain[%0d] got out=%h sel=%0d ovf=%b exp out=%h sel=1 ovf=0010", k, out, lane_sel, overflow, exp_out[k]);
      end
    end
  endtask

  // -------------------------------------------------------------------------
  // Lane 2 full on the first ACTIVE edge, popped and pushed together.
  task automatic test_full_pop();
    logic [8:0] words   [5] = '{9'h1B0, 9'h1B1, 9'h1B2, 9'h1B3, 9'h1AB};
    logic [8:0] exp_out [5] = '{9'h1B1, 9'h1B2, 9'h1B3, 9'h1AB, 9'h07C};
    do_reset();
    for (int k = 0; k < 5; k++) begin
      in2 = words[k];
      cycle();
      if (k == 3) begin
        checks++;
        if (full !== 4'b0100) begin
          errors++; $display("FAIL fullpop_full got=%b exp=0100", full);
        end
      end
    end
    clear_inputs();
    checks++;
    if (out !== 9'h1B0 || lane_sel !== 2'd2) begin
      errors++; $display("FAIL fullpop_first got out=%h sel=%0d exp out=%h sel=2", out, lane_sel, 9'h1B0);
    end
    checks++;
    if (full !== 4'b0100 || overflow !== 4'b0000) begin
      errors++; $display("FAIL fullpop_accept got full=%b ovf=%b exp full=0100 ovf=0000", full, overflow);
    end
    for (int k = 0; k < 5; k++) begin
      cycle();
      checks++;
      if (out !== exp_out[k] || lane_sel !== 2'd2 || overflow !== 4'b0000) begin
        errors++; $display("FAIL fullpop_drain[%0d] got out=%h sel=%0d ovf=%b exp out=%h sel=2 ovf=0000", k, out, lane_sel, overflow, exp_out[k]);
      end
    end
  endtask

  // -------------------------------------------------------------------------
  task automatic test_reset_mid();
    do_reset();
    for (int k = 0; k < 3; k++) begin
      in0 = {1'b1, 8'h30 + 8'(k)};
      cycle();
    end
    clear_inputs();
    cycle();
    checks++;
    if (sync_done !== 1'b1 || out !== 9'h0BC) begin
      errors++; $display("FAIL mid_before got done=%b out=%h exp done=1 out=%h", sync_done, out, 9'h0BC);
    end
    // Asynchronous assertion between edges.
    reset = 1'b0;
    #1;
    checks++;
    if (out !== 9'h000 || sync_done !== 1'b0 || lane_sel !== 2'd0 || full !== 4'b0000 || overflow !== 4'b0000) begin
      errors++; $display("FAIL mid_async_clear got out=%h done=%b sel=%0d full=%b ovf=%b exp all zero", out, sync_done, lane_sel, full, overflow);
    end
    cycle();
    reset = 1'b1;
    for (int k = 1; k <= 4; k++) begin
      cycle();
      checks++;
      if (out !== 9'h0BC || sync_done !== (k == 4)) begin
        errors++; $display("FAIL mid_preamble[%0d] got out=%h done=%b exp out=%h done=%b", k, out, sync_done, 9'h0BC, (k == 4));
      end
    end
    for (int k = 0; k < 4; k++) begin
      cycle();
      checks++;
      if (out !== 9'h07C) begin
        errors++; $display("FAIL mid_discarded[%0d] got out=%h exp=%h", k, out, 9'h07C);
      end
    end
  endtask

  // -------------------------------------------------------------------------
  initial begin
    test_reset();
    test_sync_preload();
    test_ptr_wrap();
    test_overflow();
    test_full_pop();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
